// File: rtl/lcd_timing_gen.sv
// RGB LCD timing master: HS/VS/DE/backlight generation plus pixel coordinate requests
// issued DATA_LAT cycles ahead of DE so the returned pixel_data lines up with lcd_de.
module lcd_timing_gen #(
    parameter logic [10:0] H_SYNC   = 11'd41,
    parameter logic [10:0] H_BACK   = 11'd2,
    parameter logic [10:0] H_DISP   = 11'd480,
    parameter logic [10:0] H_FRONT  = 11'd2,
    parameter logic [10:0] V_SYNC   = 11'd10,
    parameter logic [10:0] V_BACK   = 11'd2,
    parameter logic [10:0] V_DISP   = 11'd272,
    parameter logic [10:0] V_FRONT  = 11'd2,
    parameter int          DATA_LAT = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_row,
    output logic [10:0] pixel_line,
    output logic        pixel_req,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] HA        = H_SYNC + H_BACK;
    localparam logic [10:0] VA        = V_SYNC + V_BACK;
    localparam logic [10:0] REQ_START = HA - 11'(DATA_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, req_q, req_d;
    logic        bl_q, bl_d, fd_q, fd_d;
    logic [10:0] row_q, row_d, line_q, line_d;
    logic [15:0] fc_q, fc_d;

    logic        h_last, v_last, frame_last, active, in_v;
    logic [10:0] req_off, de_off, v_off;

    assign h_disp = H_DISP;
    assign v_disp = V_DISP;

    always_comb begin
        h_last     = (h_cnt_q == H_TOTAL - 11'd1);
        v_last     = (v_cnt_q == V_TOTAL - 11'd1);
        frame_last = h_last && v_last;
        state_d    = state_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = RUN;
            end
            default: begin
                h_cnt_d = h_last ? 11'd0 : h_cnt_q + 11'd1;
                if (h_last) v_cnt_d = v_last ? 11'd0 : v_cnt_q + 11'd1;
                // Stopping only ever happens on a frame boundary; en mid-frame just selects RUN/DRAIN.
                if (frame_last) state_d = en ? RUN : IDLE;
                else            state_d = en ? RUN : DRAIN;
            end
        endcase
    end

    // Window tests use modular offsets so a zero start never yields a constant comparison.
    always_comb begin
        active  = (state_q != IDLE);
        req_off = h_cnt_q - REQ_START;
        de_off  = h_cnt_q - HA;
        v_off   = v_cnt_q - VA;
        in_v    = (v_off < v_disp);
        hs_d    = !(active && (h_cnt_q < H_SYNC));
        vs_d    = !(active && (v_cnt_q < V_SYNC));
        de_d    = active && in_v && (de_off < h_disp);
        req_d   = active && in_v && (req_off < h_disp);
        row_d   = req_d ? req_off : 11'd0;
        line_d  = req_d ? v_off : 11'd0;
        bl_d    = active;
        fd_d    = active && frame_last;
        fc_d    = fd_d ? fc_q + 16'd1 : fc_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            req_q   <= 1'b0;
            row_q   <= '0;
            line_q  <= '0;
            bl_q    <= 1'b0;
            fd_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            req_q   <= req_d;
            row_q   <= row_d;
            line_q  <= line_d;
            bl_q    <= bl_d;
            fd_q    <= fd_d;
            fc_q    <= fc_d;
        end
    end

    assign lcd_hs     = hs_q;
    assign lcd_vs     = vs_q;
    assign lcd_de     = de_q;
    assign pixel_req  = req_q;
    assign pixel_row  = row_q;
    assign pixel_line = line_q;
    assign lcd_bl     = bl_q;
    assign frame_done = fd_q;
    assign frame_cnt  = fc_q;
    assign lcd_rgb    = de_q ? pixel_data : 24'h000000;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: three small-parameter instances (DATA_LAT 0/1/5) against a
// frame-position model, plus a one-cycle-frame instance that exercises the frame_cnt wrap.
module tb_lcd_timing_gen;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic rst_f = 1'b1;
    logic en_f  = 1'b1;

    always #5 pclk = ~pclk;

    logic [10:0] row_w [3];
    logic [10:0] line_w [3];
    logic [10:0] hd_w [3];
    logic [10:0] vd_w [3];
    logic        req_w [3];
    logic        hs_w [3];
    logic        vs_w [3];
    logic        de_w [3];
    logic        bl_w [3];
    logic        fd_w [3];
    logic [23:0] rgb_w [3];
    logic [23:0] pd_w [3];
    logic [15:0] fc_w [3];

    function automatic int dl_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 5);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int DL = (gi == 0) ? 0 : ((gi == 1) ? 1 : 5);
        localparam int PI = (DL == 0) ? 1 : DL;
        logic [23:0] src;
        logic [23:0] pipe [1:5];
        // Pixel source: returns {row,line} exactly DL cycles after the request.
        assign src = {2'b00, row_w[gi], line_w[gi]};
        always @(posedge pclk) begin
            pipe[1] <= src;
            for (int k = 2; k <= 5; k++) pipe[k] <= pipe[k-1];
        end
        assign pd_w[gi] = (DL == 0) ? src : pipe[PI];

        lcd_timing_gen #(
            .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
            .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
            .DATA_LAT(DL)
        ) u_dut (
            .pclk(pclk), .rst(rst), .en(en), .pixel_data(pd_w[gi]),
            .pixel_row(row_w[gi]), .pixel_line(line_w[gi]), .pixel_req(req_w[gi]),
            .h_disp(hd_w[gi]), .v_disp(vd_w[gi]),
            .lcd_hs(hs_w[gi]), .lcd_vs(vs_w[gi]), .lcd_de(de_w[gi]), .lcd_rgb(rgb_w[gi]),
            .lcd_bl(bl_w[gi]), .frame_done(fd_w[gi]), .frame_cnt(fc_w[gi])
        );
    end

    logic [10:0] f_row, f_line, f_hd, f_vd;
    logic        f_req, f_hs, f_vs, f_de, f_bl, f_fd;
    logic [23:0] f_rgb;
    logic [15:0] f_fc;

    lcd_timing_gen #(
        .H_SYNC(11'd1), .H_BACK(11'd0), .H_DISP(11'd0), .H_FRONT(11'd0),
        .V_SYNC(11'd1), .V_BACK(11'd0), .V_DISP(11'd0), .V_FRONT(11'd0),
        .DATA_LAT(0)
    ) u_fast (
        .pclk(pclk), .rst(rst_f), .en(en_f), .pixel_data(24'h000000),
        .pixel_row(f_row), .pixel_line(f_line), .pixel_req(f_req),
        .h_disp(f_hd), .v_disp(f_vd),
        .lcd_hs(f_hs), .lcd_vs(f_vs), .lcd_de(f_de), .lcd_rgb(f_rgb),
        .lcd_bl(f_bl), .frame_done(f_fd), .frame_cnt(f_fc)
    );

    typedef struct packed {
        logic        hs, vs, de, req, bl, fd;
        logic [10:0] row, line;
        logic [23:0] rgb;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit          m_active = 0;
    int          m_t      = 0;
    logic [15:0] m_fc     = 16'd0;
    bit          fm_active  = 0;
    logic [15:0] fm_fc      = 16'd0;
    bit          fm_wrapped = 0;

    // Frame position t = v*15 + h on the 15x8 test raster; HA=5, VA=3.
    function automatic exp_t decode(bit act, int t, int dl);
        exp_t e;
        int h, v;
        h = t % 15;
        v = t / 15;
        e.hs   = !(act && h < 2);
        e.vs   = !(act && v < 1);
        e.de   = act && h >= 5 && h < 13 && v >= 3 && v < 7;
        e.req  = act && h >= 5 - dl && h < 13 - dl && v >= 3 && v < 7;
        e.row  = e.req ? 11'(h - (5 - dl)) : 11'd0;
        e.line = e.req ? 11'(v - 3) : 11'd0;
        e.bl   = act;
        e.fd   = act && t == 119;
        e.rgb  = e.de ? {2'b00, 11'(h - 5), 11'(v - 3)} : 24'h000000;
        return e;
    endfunction

    task automatic chk(string name, int inst, logic [31:0] got, logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d: got %0h expected %0h", name, inst, cyc, got, expv);
        end
    endtask

    task automatic tick();
        exp_t e [3];
        bit   skip, skip_f, fd_f_exp;
        skip = rst;
        for (int k = 0; k < 3; k++) e[k] = decode(rst ? 1'b0 : m_active, m_t, dl_of(k));
        if (rst) begin
            m_fc = 16'd0; m_active = 0; m_t = 0;
        end else begin
            if (e[0].fd) m_fc = m_fc + 16'd1;
            if (!m_active) begin
                if (en) m_active = 1;
            end else if (m_t == 119) begin
                m_t = 0;
                m_active = en;
            end else begin
                m_t++;
            end
        end
        skip_f = rst_f;
        fd_f_exp = 0;
        if (rst_f) begin
            fm_active = 0; fm_fc = 16'd0;
        end else begin
            fd_f_exp = fm_active;
            if (fm_active) begin
                if (fm_fc == 16'hFFFF) fm_wrapped = 1;
                fm_fc = fm_fc + 16'd1;
            end
            fm_active = en_f;
        end

        @(posedge pclk);
        #1;
        cyc++;

        for (int k = 0; k < 3; k++) begin
            chk("frame_cnt", k, 32'(fc_w[k]), 32'(m_fc));
            if (!skip) begin
                chk("lcd_hs", k, 32'(hs_w[k]), 32'(e[k].hs));
                chk("lcd_vs", k, 32'(vs_w[k]), 32'(e[k].vs));
                chk("lcd_de", k, 32'(de_w[k]), 32'(e[k].de));
                chk("pixel_req", k, 32'(req_w[k]), 32'(e[k].req));
                chk("pixel_row", k, 32'(row_w[k]), 32'(e[k].row));
                chk("pixel_line", k, 32'(line_w[k]), 32'(e[k].line));
                chk("lcd_bl", k, 32'(bl_w[k]), 32'(e[k].bl));
                chk("frame_done", k, 32'(fd_w[k]), 32'(e[k].fd));
                chk("lcd_rgb", k, 32'(rgb_w[k]), 32'(e[k].rgb));
            end
        end
        if (fm_fc < 16'd4 || fm_fc > 16'hFFFB) begin
            chk("fast_frame_cnt", 3, 32'(f_fc), 32'(fm_fc));
            if (!skip_f) chk("fast_frame_done", 3, 32'(f_fd), 32'(fd_f_exp));
        end
    endtask

    typedef struct {
        logic rst, en, check;
        logic hs, vs, bl, de;
    } vec_t;

    initial begin
        vec_t        tbl [10];
        int          guard;
        int          hs_low, vs_low, de_total, de_run, de_lines8, fd_cnt, fd_first, fd_second;
        int          rgb_bad, bl_low;
        int          req_cnt [3], req_first [3], de_first [3], req_run [3], req_max [3];
        logic [23:0] rgb_l2;
        logic [15:0] fc_hold;

        // Reset, IDLE->RUN entry (first HS low one cycle after entering RUN), re-reset.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            tick();
            rst_f = 1'b0;
            chk("tbl_frame_cnt", i, 32'(fc_w[1]), 32'd0);
            if (tbl[i].check) begin
                chk("tbl_hs", i, 32'(hs_w[1]), 32'(tbl[i].hs));
                chk("tbl_vs", i, 32'(vs_w[1]), 32'(tbl[i].vs));
                chk("tbl_bl", i, 32'(bl_w[1]), 32'(tbl[i].bl));
                chk("tbl_de", i, 32'(de_w[1]), 32'(tbl[i].de));
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk("h_disp", k, 32'(hd_w[k]), 32'd8);
            chk("v_disp", k, 32'(vd_w[k]), 32'd4);
        end

        // Two full frames from a frame start: counts, widths and req->de offsets.
        guard = 0;
        while (m_t != 0 && guard < 500) begin tick(); guard++; end
        hs_low = 0; vs_low = 0; de_total = 0; de_run = 0; de_lines8 = 0;
        fd_cnt = 0; fd_first = -1; fd_second = -1; rgb_bad = 0; rgb_l2 = 24'hFFFFFF;
        for (int k = 0; k < 3; k++) begin
            req_cnt[k] = 0; req_first[k] = -1; de_first[k] = -1; req_run[k] = 0; req_max[k] = 0;
        end
        for (int i = 0; i < 240; i++) begin
            tick();
            if (!hs_w[1]) hs_low++;
            if (!vs_w[1]) vs_low++;
            if (de_w[1]) begin
                de_total++; de_run++;
            end else begin
                if (de_run == 8) de_lines8++;
                de_run = 0;
            end
            if (fd_w[1]) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
                else if (fd_second < 0) fd_second = i;
            end
            if (!de_w[1] && rgb_w[1] != 24'h0) rgb_bad++;
            if (i == 80) rgb_l2 = rgb_w[1];
            for (int k = 0; k < 3; k++) begin
                if (req_w[k]) begin
                    req_cnt[k]++; req_run[k]++;
                    if (req_first[k] < 0) req_first[k] = i;
                end else begin
                    req_run[k] = 0;
                end
                if (req_run[k] > req_max[k]) req_max[k] = req_run[k];
                if (de_w[k] && de_first[k] < 0) de_first[k] = i;
            end
        end
        chk("hs_low_cycles", 1, 32'(hs_low), 32'd32);
        chk("vs_low_cycles", 1, 32'(vs_low), 32'd30);
        chk("de_cycles", 1, 32'(de_total), 32'd64);
        chk("de_lines_of_8", 1, 32'(de_lines8), 32'd8);
        chk("frame_done_count", 1, 32'(fd_cnt), 32'd2);
        chk("frame_done_first", 1, 32'(fd_first), 32'd119);
        chk("frame_done_period", 1, 32'(fd_second - fd_first), 32'd120);
        chk("rgb_when_no_de", 1, 32'(rgb_bad), 32'd0);
        chk("rgb_line2_first", 1, 32'(rgb_l2), 32'h000002);
        for (int k = 0; k < 3; k++) begin
            chk("req_cycles", k, 32'(req_cnt[k]), 32'd64);
            chk("req_width", k, 32'(req_max[k]), 32'd8);
            chk("req_to_de_offset", k, 32'(de_first[k] - req_first[k]), 32'(dl_of(k)));
        end

        // Drop en at v=3: frame completes, then stays idle with frame_cnt frozen.
        guard = 0;
        while (m_t != 45 && guard < 500) begin tick(); guard++; end
        en = 1'b0;
        fd_cnt = 0; guard = 0;
        while (m_active && guard < 300) begin
            tick(); guard++;
            if (fd_w[1]) fd_cnt++;
        end
        chk("drain_frame_done", 1, 32'(fd_cnt), 32'd1);
        fc_hold = fc_w[1];
        for (int i = 0; i < 20; i++) tick();
        chk("idle_frame_cnt_frozen", 1, 32'(fc_w[1]), 32'(fc_hold));
        chk("idle_bl", 1, 32'(bl_w[1]), 32'd0);
        chk("idle_hs", 1, 32'(hs_w[1]), 32'd1);
        chk("idle_vs", 1, 32'(vs_w[1]), 32'd1);

        // Re-assert en at the same position: no gap in frames.
        en = 1'b1;
        guard = 0;
        while (m_t != 45 && guard < 500) begin tick(); guard++; end
        en = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        en = 1'b1;
        bl_low = 0; fd_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!bl_w[1]) bl_low++;
            if (fd_w[1]) fd_cnt++;
        end
        chk("resume_bl_gap", 1, 32'(bl_low), 32'd0);
        chk("resume_frame_done", 1, 32'(fd_cnt), 32'd2);

        // Reset while DE is high mid-line.
        guard = 0;
        while (m_t != 52 && guard < 500) begin tick(); guard++; end
        tick();
        chk("pre_reset_de", 1, 32'(de_w[1]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_de", 1, 32'(de_w[1]), 32'd0);
        chk("post_reset_rgb", 1, 32'(rgb_w[1]), 32'd0);
        chk("post_reset_frame_cnt", 1, 32'(fc_w[1]), 32'd0);
        chk("post_reset_bl", 1, 32'(bl_w[1]), 32'd0);

        // Random en toggling with occasional reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(39) == 0) en = ~en;
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        en  = 1'b1;

        // One-cycle frames on the fast instance carry frame_cnt through 16'hFFFF -> 0.
        guard = 0;
        while (!(fm_wrapped && fm_fc == 16'd3) && guard < 70000) begin tick(); guard++; end
        if (!(fm_wrapped && fm_fc == 16'd3)) chk("wrap_timeout", 3, 32'(f_fc), 32'd3);
        chk("wrap_seen", 3, 32'(fm_wrapped), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
